// File: rtl/io_uart_in_pkg.sv
// Shared IO definitions for the UART receive block: register addresses,
// RXSTAT/RXCTRL bit positions and the word-address decoder.
package io_uart_in_pkg;

  localparam logic [15:0] IO_RXDATA_ADR = 16'hC800;
  localparam logic [15:0] IO_RXSTAT_ADR = 16'hC804;
  localparam logic [15:0] IO_RXCTRL_ADR = 16'hC808;

  localparam int unsigned RXSTAT_NE_BIT   = 0;
  localparam int unsigned RXSTAT_FULL_BIT = 1;
  localparam int unsigned RXSTAT_OVR_BIT  = 2;
  localparam int unsigned RXSTAT_CNT_LSB  = 4;
  localparam int unsigned RXSTAT_CNT_W    = 7;

  localparam int unsigned RXCTRL_IRQEN_BIT = 0;
  localparam int unsigned RXCTRL_FLUSH_BIT = 1;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_RXDATA,
    REG_RXSTAT,
    REG_RXCTRL
  } io_reg_e;

  function automatic io_reg_e io_decode(input logic [15:2] adr);
    if (adr == IO_RXDATA_ADR[15:2]) return REG_RXDATA;
    if (adr == IO_RXSTAT_ADR[15:2]) return REG_RXSTAT;
    if (adr == IO_RXCTRL_ADR[15:2]) return REG_RXCTRL;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/io_rx_fifo.sv
// Synchronous byte FIFO for the UART receive path: push, pop, flush,
// full/empty flags and an occupancy count of 0..DEPTH.
module io_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          push_ok, pop_ok;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rptr];

  // A pop in the same cycle frees the slot, so a push at full still fits.
  assign pop_ok  = pop & ~empty & ~flush;
  assign push_ok = push & (~full | pop_ok) & ~flush;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_uart_in.sv
// UART receive IO block: RXDATA/RXSTAT/RXCTRL registers on the IO daisy chain.
// Optional interrupt support is built when IO_UART_IN_IRQ_EN is defined.
module io_uart_in
  import io_uart_in_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  uart_rx_char,
  input  logic        uart_rx_we,
  input  logic        dma_io_we,
  input  logic [15:2] dma_io_wadr,
  input  logic [31:0] dma_io_wdata,
  input  logic [15:2] dma_io_radr,
  input  logic        dma_io_radr_en,
  input  logic [31:0] dma_io_rdata_in,
  output logic [31:0] dma_io_rdata,
  output logic        rx_irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  io_reg_e       rsel, wsel;
  logic          rd_pop, flush, ovr_set, ovr_clr, overrun, irq_en_rd;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          hit_q;
  logic [31:0]   rd_q, rd_val;

  assign rsel    = dma_io_radr_en ? io_decode(dma_io_radr) : REG_NONE;
  assign wsel    = dma_io_we ? io_decode(dma_io_wadr) : REG_NONE;
  assign rd_pop  = (rsel == REG_RXDATA);
  assign flush   = (wsel == REG_RXCTRL) & dma_io_wdata[RXCTRL_FLUSH_BIT];
  assign ovr_clr = (wsel == REG_RXSTAT) & dma_io_wdata[RXSTAT_OVR_BIT];
  // A drop only happens when no same-cycle pop makes room and no flush wins.
  assign ovr_set = uart_rx_we & fifo_full & ~rd_pop & ~flush;

  io_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (uart_rx_we),
    .pop   (rd_pop),
    .flush (flush),
    .din   (uart_rx_char),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    rd_val = '0;
    case (rsel)
      REG_RXDATA: if (!fifo_empty) rd_val[7:0] = fifo_dout;
      REG_RXSTAT: begin
        rd_val[RXSTAT_CNT_LSB +: RXSTAT_CNT_W] = RXSTAT_CNT_W'(fifo_count);
        rd_val[RXSTAT_OVR_BIT]  = overrun;
        rd_val[RXSTAT_FULL_BIT] = fifo_full;
        rd_val[RXSTAT_NE_BIT]   = ~fifo_empty;
      end
      REG_RXCTRL: rd_val[RXCTRL_IRQEN_BIT] = irq_en_rd;
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
      hit_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      if (ovr_set)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
      hit_q <= (rsel != REG_NONE);
      rd_q  <= rd_val;
    end
  end

  assign dma_io_rdata = hit_q ? rd_q : dma_io_rdata_in;

`ifdef IO_UART_IN_IRQ_EN
  logic irq_en, irq_q;
  logic unused_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (wsel == REG_RXCTRL) irq_en <= dma_io_wdata[RXCTRL_IRQEN_BIT];
      irq_q <= irq_en & (~fifo_empty | overrun);
    end
  end

  assign irq_en_rd    = irq_en;
  assign rx_irq       = irq_q;
  assign unused_wdata = ^dma_io_wdata[31:3];
`else
  logic unused_wdata;

  assign irq_en_rd    = 1'b0;
  assign rx_irq       = 1'b0;
  assign unused_wdata = ^{dma_io_wdata[31:3], dma_io_wdata[0]};
`endif

endmodule
